// File: rtl/load_cache_arbiter_pkg.sv
// Shared constants for the load/cache arbiter slice:
// word width, miss latency default, FSM state encoding.
package load_cache_arbiter_pkg;

  localparam int WORD_SIZE_DEF = 32;
  localparam int MISS_LAT_DEF  = 4;
  localparam int N_REQ_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MISS,
    RESP
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/load_cache_arbiter_rr_pick.sv
// Combinational N_REQ-way round-robin selector.
// Ports: req, rr_ptr in; any, winner out.
module load_cache_arbiter_rr_pick
  import load_cache_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic             any,
  output logic [IW-1:0]    winner
);

  always_comb begin : pick
    int          j;
    logic [IW-1:0] idx;
    j      = 0;
    idx    = '0;
    any    = 1'b0;
    winner = '0;
    // First requester found walking up from rr_ptr, wrapping at N_REQ.
    for (int i = 0; i < N_REQ; i++) begin
      j   = (int'(rr_ptr) + i) % N_REQ;
      idx = IW'(j);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/load_cache_arbiter.sv
// Arbitrates load stations onto one cache read port.
// Ports: clk, reset (sync, low), req/addr in, rsp_valid/rsp_data out, c_* cache side.
module load_cache_arbiter
  import load_cache_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int MISS_LAT  = MISS_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WORD_SIZE-1:0] addr,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [WORD_SIZE-1:0]       rsp_data,
  output logic [WORD_SIZE-1:0]       c_ptr,
  output logic                       c_read_enable,
  input  logic [WORD_SIZE-1:0]       c_out,
  input  logic                       c_hit
);

  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(MISS_LAT) + 1;

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  win;
  logic [CW-1:0]  miss_cnt;
  logic           any;
  logic [IW-1:0]  pick;
  logic [WORD_SIZE-1:0] addr_w [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign addr_w[g] = addr[g*WORD_SIZE +: WORD_SIZE];
  end

  load_cache_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (any),
    .winner (pick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      win           <= '0;
      miss_cnt      <= '0;
      c_read_enable <= 1'b0;
      rsp_valid     <= '0;
      c_ptr         <= '0;
      rsp_data      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          rsp_valid <= '0;
          if (any) begin
            win           <= pick;
            c_ptr         <= addr_w[pick];
            c_read_enable <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          // A flushed station abandons the read silently.
          if (!req[win]) begin
            c_read_enable <= 1'b0;
            state         <= IDLE;
          end else if (c_hit) begin
            rsp_data      <= c_out;
            rsp_valid     <= N_REQ'(1) << win;
            c_read_enable <= 1'b0;
            state         <= RESP;
          end else begin
            miss_cnt <= CW'(MISS_LAT - 1);
            state    <= MISS;
          end
        end
        MISS: begin
          if (!req[win]) begin
            c_read_enable <= 1'b0;
            state         <= IDLE;
          end else if (miss_cnt == '0) begin
            rsp_data      <= c_out;
            rsp_valid     <= N_REQ'(1) << win;
            c_read_enable <= 1'b0;
            state         <= RESP;
          end else begin
            miss_cnt <= miss_cnt - 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          rr_ptr    <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_cache_arbiter.sv
// Scoreboard bench for load_cache_arbiter.
// Instance a: 2 stations; instance b: 3 stations for wrap-around.
module tb_load_cache_arbiter;

  localparam int W = 32;

  typedef struct {
    logic [2:0]   v;
    logic [W-1:0] d;
    logic [W-1:0] a;
    int           at;
    int           re;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]     req_a = '0;
  logic [2*W-1:0] addr_a = '0;
  logic [1:0]     rv_a;
  logic [W-1:0]   rd_a, cp_a, co_a;
  logic           cre_a;
  logic           hit_a = 1'b1;
  logic           use_fixed = 1'b1;
  logic [W-1:0]   fixed_data = '0;

  logic [2:0]     req_b = '0;
  logic [3*W-1:0] addr_b = '0;
  logic [2:0]     rv_b;
  logic [W-1:0]   rd_b, cp_b, co_b;
  logic           cre_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   run_a = 0;
  int   last_a = 0;

  assign co_a = use_fixed ? fixed_data : cp_a + 32'h1000;
  assign co_b = cp_b + 32'h1000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_cache_arbiter #(
    .N_REQ(2), .WORD_SIZE(W), .MISS_LAT(4)
  ) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .addr(addr_a),
    .rsp_valid(rv_a), .rsp_data(rd_a), .c_ptr(cp_a),
    .c_read_enable(cre_a), .c_out(co_a), .c_hit(hit_a)
  );

  load_cache_arbiter #(
    .N_REQ(3), .WORD_SIZE(W), .MISS_LAT(4)
  ) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .addr(addr_b),
    .rsp_valid(rv_b), .rsp_data(rd_b), .c_ptr(cp_b),
    .c_read_enable(cre_b), .c_out(co_b), .c_hit(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [1:0] v, input logic [W-1:0] d,
                        input logic [W-1:0] a, input int lat, input int re);
    exp_t e;
    e.v = {1'b0, v}; e.d = d; e.a = a; e.at = cyc + lat; e.re = re;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [2:0] v, input logic [W-1:0] d,
                        input logic [W-1:0] a, input int lat);
    exp_t e;
    e.v = v; e.d = d; e.a = a; e.at = cyc + lat; e.re = -1;
    q_b.push_back(e);
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while ((req_a != 0 || q_a.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk("a_drain", n < 60, 1);
    tick();
    tick();
  endtask

  task automatic wait_idle_b();
    int n;
    n = 0;
    while ((req_b != 0 || q_b.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk("b_drain", n < 60, 1);
    tick();
    tick();
  endtask

  // Monitor: pops the scoreboard on each response pulse; the
  // station drops its request once it has seen its pulse.
  always @(negedge clk) begin
    if (cre_a === 1'b1) run_a++;
    else if (run_a != 0) begin
      last_a = run_a;
      run_a  = 0;
    end
    if (|rv_a) begin
      if (q_a.size() == 0) chk("a_unexpected_rsp", rv_a, 0);
      else begin
        ea = q_a.pop_front();
        chk("a_rsp_valid", rv_a, ea.v);
        chk("a_rsp_data", rd_a, ea.d);
        chk("a_c_ptr", cp_a, ea.a);
        chk("a_rsp_cycle", cyc, ea.at);
        if (ea.re >= 0) chk("a_re_cycles", last_a, ea.re);
      end
      req_a = req_a & ~rv_a;
    end
  end

  always @(negedge clk) begin
    if (|rv_b) begin
      if (q_b.size() == 0) chk("b_unexpected_rsp", rv_b, 0);
      else begin
        eb = q_b.pop_front();
        chk("b_rsp_valid", rv_b, eb.v);
        chk("b_rsp_data", rd_b, eb.d);
        chk("b_c_ptr", cp_b, eb.a);
        chk("b_rsp_cycle", cyc, eb.at);
      end
      req_b = req_b & ~rv_b;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    tick();
    tick();
    chk("rst_rsp_valid", rv_a, 0);
    chk("rst_re", cre_a, 0);
    chk("rst_c_ptr", cp_a, 0);
    chk("rst_rsp_data", rd_a, 0);
    chk("rst_b_rsp_valid", rv_b, 0);
    chk("rst_b_re", cre_b, 0);
    reset = 1'b1;
    tick();

    // Single hit.
    use_fixed = 1'b1; fixed_data = 32'h1234; hit_a = 1'b1;
    addr_a = {32'h0, 32'h40};
    push_a(2'b01, 32'h1234, 32'h40, 2, 1);
    req_a = 2'b01;
    tick();
    chk("hit_re_high", cre_a, 1);
    chk("hit_c_ptr", cp_a, 32'h40);
    tick();
    chk("hit_re_low", cre_a, 0);
    wait_idle_a();

    // Miss, four extra cycles.
    fixed_data = 32'hBEEF; hit_a = 1'b0;
    addr_a = {32'h0, 32'h80};
    push_a(2'b01, 32'hBEEF, 32'h80, 6, 5);
    req_a = 2'b01;
    wait_idle_a();

    // Reset in the middle of a miss.
    req_a = 2'b01;
    tick(); tick(); tick();
    chk("mid_miss_re", cre_a, 1);
    reset = 1'b0;
    req_a = 2'b00;
    tick();
    chk("mreset_rsp_valid", rv_a, 0);
    chk("mreset_re", cre_a, 0);
    chk("mreset_c_ptr", cp_a, 0);
    chk("mreset_rsp_data", rd_a, 0);
    reset = 1'b1;
    tick(); tick();

    // Contention straight after reset: 0, 1, then 0 again.
    use_fixed = 1'b0; hit_a = 1'b1;
    addr_a = {32'h200, 32'h100};
    push_a(2'b01, 32'h1100, 32'h100, 2, 1);
    push_a(2'b10, 32'h1200, 32'h200, 5, 1);
    push_a(2'b01, 32'h1100, 32'h100, 8, 1);
    req_a = 2'b11;
    tick(); tick(); tick();
    req_a = req_a | 2'b01;
    wait_idle_a();

    // Station 1 flushed during its miss; station 0 then served.
    hit_a = 1'b0;
    addr_a = {32'h400, 32'h300};
    push_a(2'b01, 32'h1300, 32'h300, 10, 5);
    req_a = 2'b11;
    tick(); tick(); tick();
    req_a[1] = 1'b0;
    tick();
    chk("cancel_re_low", cre_a, 0);
    chk("cancel_no_rsp", rv_a, 0);
    wait_idle_a();

    // Three stations: serve 1 so rr_ptr=2, then 101 wraps 2 -> 0.
    addr_b = {32'h30, 32'h20, 32'h10};
    push_b(3'b010, 32'h1020, 32'h20, 2);
    req_b = 3'b010;
    wait_idle_b();
    push_b(3'b100, 32'h1030, 32'h30, 2);
    push_b(3'b001, 32'h1010, 32'h10, 5);
    req_b = 3'b101;
    wait_idle_b();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
